instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the control-unit decode path: packs RV32I instruction fields (opcode, funct3, funct7, rd, rs1, rs2, imm) into 32-bit machine words.
- Emits words over a valid/ready stream with a sequential word address, ready to write instruction memory.
- Used by the self-test loader and benches to build programs that the datapath then fetches and decodes.
- One registered output stage with backpressure; unsupported opcodes are counted and dropped.

Parameters:
- ADDR_W, 10: width of the output byte-address counter.
- BASE_ADDR, 0: address of the first emitted word; must be a multiple of 4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted when in_valid && in_ready.
- opcode  in  7  instruction opcode.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field; for R-type and I-type shifts only.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- imm  in  32  sign-extended immediate value; for U-type, imm[31:12] is used.
- out_valid  out  1  out_instr/out_addr valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- err_opcode  out  1  one-cycle pulse: an accepted bundle had an unsupported opcode.
- word_count  out  16  number of words emitted (handshakes completed).
- err_count  out  8  number of dropped bundles; saturates at 255.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_opcode=0, word_count=0, err_count=0.
  - in_ready may be 1 immediately after reset deassertion.
- in_ready = !out_valid || out_ready (combinational, single-entry pipeline). Full throughput of 1 word/cycle under continuous out_ready.
- Latency: a bundle accepted in cycle N presents on out_* in cycle N+1.
- Encoding, by opcode:
  - R (0110011): {funct7, rs2, rs1, funct3, rd, opcode}.
  - I (0010011, 0000011, 1100111): {imm[11:0], rs1, funct3, rd, opcode}.
  - I shift (0010011 with funct3 001 or 101): imm[11:5] is replaced by funct7; imm[4:0] is the shamt.
  - S (0100011): {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - U (0110111, 0010111): {imm[31:12], rd, opcode}.
  - Fields not used by a format are ignored.
- Unsupported opcode:
  - The bundle is still accepted (in_ready unchanged) but not emitted.
  - err_opcode pulses high in the following cycle.
  - err_count increments (saturating); out_addr and word_count are unchanged.
- Output hold: while out_valid && !out_ready, out_instr and out_addr are held stable; no new bundle is accepted.
- Output handshake: on out_valid && out_ready, out_addr advances by 4 and word_count increments by 1.
  - Both wrap modulo 2^ADDR_W and 2^16 respectively, with no flag.
- Simultaneous drain and accept in the same cycle: the output is replaced by the new word; out_valid stays 1.
- Reset mid-transfer: any pending word is discarded; the counters clear.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined:
  - An accepted bundle is dropped exactly like an unsupported opcode (err_opcode pulse, err_count++) if:
    - its imm does not fit the format's signed range (I/S: -2048..2047, B: -4096..4094, J: ±1 MiB), or
    - B/J imm[0]=1, or
    - U imm[11:0]!=0.
- Undefined: no range check; imm bits are truncated silently.

Test Plan:
- R-type add x3,x1,x2 (opcode 0110011, funct3 000, funct7 0000000, rd 3, rs1 1, rs2 2), out_ready=1 -> out_instr=0x002081B3, out_addr=0x000 one cycle after accept, word_count=1.
- I-type addi x5,x0,-1, then srai x6,x7,3 (funct3 101, funct7 0100000) back-to-back -> 0xFFF00293 at 0x000, then 0x4033D313 at 0x004; in_ready stays 1.
- B-type beq x1,x2,+8, with out_ready held 0 for 3 cycles -> out_instr=0x00208463 held stable, in_ready=0 throughout; one cycle after out_ready=1, out_addr advances.
- J jal x1,+2048 and U lui x10,0x12345000 -> 0x001000EF, then 0x12345537.
- opcode 1111111 accepted -> no out_valid, err_opcode pulse, err_count=1, next valid word still at the unchanged address.
- rst_n low mid-stall with a word pending -> out_valid=0, out_addr=BASE_ADDR, counters 0; with IMM_RANGE_CHECK_EN defined, addi with imm=4096 is dropped and err_count increments.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I field-bundle to machine-word encoder with a single registered output stage.
// Optional IMM_RANGE_CHECK_EN drops bundles whose immediate cannot be encoded exactly.
`timescale 1ns/1ps
module instr_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_opcode,
  output logic [15:0]       word_count,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Returns {emit, word}; emit=0 means the bundle must be dropped.
  function automatic logic [32:0] encode(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [4:0] d,
                                         input logic [4:0] s1, input logic [4:0] s2,
                                         input logic [31:0] im);
    logic [31:0]        w;
    logic               ok;
    logic signed [31:0] si;
    w  = '0;
    ok = 1'b1;
    si = im;
    case (op)
      OP_R: w = {f7, s2, s1, f3, d, op};
      OP_IMM, OP_LOAD, OP_JALR: begin
        if (op == OP_IMM && (f3 == 3'b001 || f3 == 3'b101))
          w = {f7, im[4:0], s1, f3, d, op};
        else
          w = {im[11:0], s1, f3, d, op};
`ifdef IMM_RANGE_CHECK_EN
        ok = (si >= -32'sd2048) && (si <= 32'sd2047);
`endif
      end
      OP_STORE: begin
        w = {im[11:5], s2, s1, f3, im[4:0], op};
`ifdef IMM_RANGE_CHECK_EN
        ok = (si >= -32'sd2048) && (si <= 32'sd2047);
`endif
      end
      OP_BR: begin
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
`ifdef IMM_RANGE_CHECK_EN
        ok = (si >= -32'sd4096) && (si <= 32'sd4094) && !im[0];
`endif
      end
      OP_JAL: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, op};
`ifdef IMM_RANGE_CHECK_EN
        ok = (si >= -32'sd1048576) && (si <= 32'sd1048574) && !im[0];
`endif
      end
      OP_LUI, OP_AUIPC: begin
        w = {im[31:12], d, op};
`ifdef IMM_RANGE_CHECK_EN
        ok = (im[11:0] == 12'd0);
`endif
      end
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [7:0]        ecnt_q, ecnt_d;
  logic [32:0]       enc;
  logic              accept, drain;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;
  assign enc      = encode(opcode, funct3, funct7, rd, rs1, rs2, imm);

  // Drain first so a same-cycle accept overwrites the slot at the advanced address.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    addr_d      = addr_q;
    err_d       = 1'b0;
    wcnt_d      = wcnt_q;
    ecnt_d      = ecnt_q;
    if (drain) begin
      out_valid_d = 1'b0;
      addr_d      = addr_q + ADDR_W'(4);
      wcnt_d      = wcnt_q + 16'd1;
    end
    if (accept) begin
      if (enc[32]) begin
        out_valid_d = 1'b1;
        out_instr_d = enc[31:0];
      end else begin
        err_d = 1'b1;
        if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      addr_q      <= BASE;
      err_q       <= 1'b0;
      wcnt_q      <= '0;
      ecnt_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      wcnt_q      <= wcnt_d;
      ecnt_q      <= ecnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_addr   = addr_q;
  assign err_opcode = err_q;
  assign word_count = wcnt_q;
  assign err_count  = ecnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, hand-written stall/error/reset sequences,
// and random traffic scored against a queue-based reference model.
`timescale 1ns/1ps
module tb_instr_encoder;
  localparam int ADDR_W    = 10;
  localparam int BASE_ADDR = 0;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [6:0]        opcode = '0;
  logic [2:0]        funct3 = '0;
  logic [6:0]        funct7 = '0;
  logic [4:0]        rd = '0;
  logic [4:0]        rs1 = '0;
  logic [4:0]        rs2 = '0;
  logic [31:0]       imm = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err_opcode;
  logic [15:0]       word_count;
  logic [7:0]        err_count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err_opcode(err_opcode), .word_count(word_count),
    .err_count(err_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference encoder: field placement by shift/mask arithmetic on the immediate.
  function automatic bit ref_enc(input int unsigned op, input int unsigned f3,
                                 input int unsigned f7, input int unsigned d,
                                 input int unsigned s1, input int unsigned s2,
                                 input logic [31:0] im, output logic [31:0] w);
    int unsigned iu;
    int          si;
    bit          ok;
    iu = im;
    si = im;
    ok = 1'b1;
    w  = 32'd0;
    case (op)
      'h33: w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
      'h13, 'h03, 'h67: begin
        if (op == 'h13 && (f3 == 1 || f3 == 5))
          w = (((f7 << 5) | (iu & 31)) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
        else
          w = ((iu & 'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
        if (RC && (si < -2048 || si > 2047)) ok = 1'b0;
      end
      'h23: begin
        w = (((iu >> 5) & 127) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
          | ((iu & 31) << 7) | op;
        if (RC && (si < -2048 || si > 2047)) ok = 1'b0;
      end
      'h63: begin
        w = (((iu >> 12) & 1) << 31) | (((iu >> 5) & 63) << 25) | (s2 << 20) | (s1 << 15)
          | (f3 << 12) | (((iu >> 1) & 15) << 8) | (((iu >> 11) & 1) << 7) | op;
        if (RC && (si < -4096 || si > 4094 || (iu & 1) != 0)) ok = 1'b0;
      end
      'h6F: begin
        w = (((iu >> 20) & 1) << 31) | (((iu >> 1) & 1023) << 21) | (((iu >> 11) & 1) << 20)
          | (((iu >> 12) & 255) << 12) | (d << 7) | op;
        if (RC && (si < -1048576 || si > 1048574 || (iu & 1) != 0)) ok = 1'b0;
      end
      'h37, 'h17: begin
        w = (iu & 'hFFFFF000) | (d << 7) | op;
        if (RC && (iu & 'hFFF) != 0) ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [31:0] exp_q[$];
  int unsigned m_addr   = BASE_ADDR;
  int unsigned m_wc     = 0;
  int unsigned m_ec     = 0;
  bit          err_pend = 1'b0;

  always @(negedge clk) begin
    logic [31:0] w;
    bit          mv, acc, hs;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_addr", 32'(out_addr), 32'(BASE_ADDR));
      chk("rst_err_opcode", 32'(err_opcode), 32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      exp_q.delete();
      m_addr   = BASE_ADDR;
      m_wc     = 0;
      m_ec     = 0;
      err_pend = 1'b0;
    end else begin
      mv  = (exp_q.size() != 0);
      hs  = mv && out_ready;
      acc = in_valid && (!mv || out_ready);
      chk("in_ready", 32'(in_ready), 32'(!mv || out_ready));
      chk("out_valid", 32'(out_valid), 32'(mv));
      if (mv) begin
        chk("out_instr", out_instr, exp_q[0]);
        chk("out_addr", 32'(out_addr), m_addr);
      end
      chk("err_opcode", 32'(err_opcode), 32'(err_pend));
      chk("word_count", 32'(word_count), m_wc);
      chk("err_count", 32'(err_count), m_ec);
      if (hs) begin
        void'(exp_q.pop_front());
        m_addr = (m_addr + 4) % (1 << ADDR_W);
        m_wc   = (m_wc + 1) % 65536;
      end
      err_pend = 1'b0;
      if (acc) begin
        if (ref_enc(opcode, funct3, funct7, rd, rs1, rs2, imm, w)) exp_q.push_back(w);
        else begin
          err_pend = 1'b1;
          if (m_ec < 255) m_ec++;
        end
      end
    end
  end

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  d, s1, s2;
    logic [31:0] im;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
    in_valid = 1'b1;
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    imm      = im;
  endtask

  initial begin
    vt[0]  = '{7'h33, 3'd0, 7'h00, 5'd3,  5'd1, 5'd2, 32'd0,          32'h002081B3};
    vt[1]  = '{7'h13, 3'd0, 7'h00, 5'd5,  5'd0, 5'd0, 32'hFFFFFFFF,   32'hFFF00293};
    vt[2]  = '{7'h13, 3'd5, 7'h20, 5'd6,  5'd7, 5'd0, 32'd3,          32'h4033D313};
    vt[3]  = '{7'h63, 3'd0, 7'h00, 5'd0,  5'd1, 5'd2, 32'd8,          32'h00208463};
    vt[4]  = '{7'h23, 3'd2, 7'h00, 5'd0,  5'd2, 5'd5, 32'hFFFFFFFC,   32'hFE512E23};
    vt[5]  = '{7'h6F, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'd2048,       32'h001000EF};
    vt[6]  = '{7'h37, 3'd0, 7'h00, 5'd10, 5'd0, 5'd0, 32'h12345000,   32'h12345537};
    vt[7]  = '{7'h17, 3'd0, 7'h00, 5'd2,  5'd0, 5'd0, 32'h00001000,   32'h00001117};
    vt[8]  = '{7'h03, 3'd2, 7'h00, 5'd4,  5'd3, 5'd0, 32'd8,          32'h0081A203};
    vt[9]  = '{7'h67, 3'd0, 7'h00, 5'd0,  5'd1, 5'd0, 32'd0,          32'h00008067};
    vt[10] = '{7'h63, 3'd1, 7'h00, 5'd0,  5'd3, 5'd4, 32'hFFFFFFFC,   32'hFE419EE3};
    vt[11] = '{7'h6F, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0, 32'hFFFFFFF8,   32'hFF9FF06F};

    #1 rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Vector table, one word at a time with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].op, vt[i].f3, vt[i].f7, vt[i].d, vt[i].s1, vt[i].s2, vt[i].im);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_instr", i), out_instr, vt[i].exp);
      chk($sformatf("vec%0d_addr", i), 32'(out_addr), 32'(BASE_ADDR + 4 * i));
      step();
    end
    @(negedge clk);
    chk("table_word_count", 32'(word_count), 32'd12);
    step();

    // Back-to-back addi / srai at full throughput.
    drive(7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    step();
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    drive(7'h13, 3'd5, 7'h20, 5'd6, 5'd7, 5'd0, 32'd3);
    @(negedge clk);
    chk("b2b_first", out_instr, 32'hFFF00293);
    chk("b2b_first_addr", 32'(out_addr), 32'h30);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second", out_instr, 32'h4033D313);
    chk("b2b_second_addr", 32'(out_addr), 32'h34);
    step();

    // Stalled branch: held stable, input blocked, then drained.
    out_ready = 1'b0;
    drive(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_instr", out_instr, 32'h00208463);
      chk("stall_addr", 32'(out_addr), 32'h38);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("drain_addr", 32'(out_addr), 32'h3C);
    chk("drain_valid", 32'(out_valid), 32'd0);
    step();

    // Unsupported opcode: dropped and counted, address unchanged.
    drive(7'h7F, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bad_err_pulse", 32'(err_opcode), 32'd1);
    chk("bad_no_valid", 32'(out_valid), 32'd0);
    chk("bad_err_count", 32'(err_count), 32'd1);
    step();
    drive(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_bad_addr", 32'(out_addr), 32'h3C);
    chk("after_bad_pulse", 32'(err_opcode), 32'd0);
    step();

    // Reset while a word is stalled at the output.
    out_ready = 1'b0;
    drive(7'h37, 3'd0, 7'h00, 5'd10, 5'd0, 5'd0, 32'h12345000);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pend_valid", 32'(out_valid), 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_addr", 32'(out_addr), 32'(BASE_ADDR));
    chk("async_rst_wc", 32'(word_count), 32'd0);
    chk("async_rst_ec", 32'(err_count), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Out-of-range I immediate.
    drive(7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'd4096);
    step();
    in_valid = 1'b0;
    @(negedge clk);
`ifdef IMM_RANGE_CHECK_EN
    chk("range_drop_valid", 32'(out_valid), 32'd0);
    chk("range_drop_ec", 32'(err_count), 32'd1);
`else
    chk("trunc_valid", 32'(out_valid), 32'd1);
    chk("trunc_instr", out_instr, 32'h00000293);
`endif
    step();

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic [6:0] ops[9];
      int         k;
      ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};
      k = $urandom_range(0, 11);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      opcode    = (k < 9) ? ops[k] : 7'($urandom());
      funct3    = 3'($urandom());
      funct7    = 7'($urandom());
      rd        = 5'($urandom());
      rs1       = 5'($urandom());
      rs2       = 5'($urandom());
      case ($urandom_range(0, 3))
        0:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1:       imm = $urandom();
        2:       imm = $urandom() & 32'hFFFFF000;
        default: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFFFFFE;
      endcase
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("final_err_count_sat", 32'(err_count), 32'd255);
    chk("final_drained", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
